// File: rtl/ysyx_pipe_pkg.sv
// Shared pipeline-boundary types: field widths, the EXU->WBU payload bundle
// and the occupancy encoding derived from the two slot valids.
package ysyx_pipe_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int RESULT_SRC_LENGTH = 3;
    localparam int WMASK_LENGTH      = 8;
    localparam int REG_ADDR_WIDTH    = 5;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]        pc;
        logic [DATA_WIDTH-1:0]        alu;
        logic [DATA_WIDTH-1:0]        wdata;
        logic                         memread;
        logic                         memwrite;
        logic [RESULT_SRC_LENGTH-1:0] ropcode;
        logic [WMASK_LENGTH-1:0]      wmask;
        logic [RESULT_SRC_LENGTH-1:0] resultsrc;
        logic [DATA_WIDTH-1:0]        csrread;
        logic [REG_ADDR_WIDTH-1:0]    rd;
        logic                         regwrite;
    } exwb_bundle_t;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_t;

    // Skid is only ever filled behind a valid main slot, so its valid alone means FULL.
    function automatic pipe_state_t pipe_state(logic main_valid, logic skid_valid);
        if (skid_valid) return PIPE_FULL;
        if (main_valid) return PIPE_ONE;
        return PIPE_EMPTY;
    endfunction

endpackage

// File: rtl/exu_wbu_pipe_reg_if.sv
// Valid/ready channel carrying one EXU result bundle; master drives the
// payload and valid, slave returns ready.
interface exu_wbu_pipe_reg_if;
    import ysyx_pipe_pkg::*;

    logic                         valid;
    logic                         ready;
    logic [DATA_WIDTH-1:0]        pc;
    logic [DATA_WIDTH-1:0]        alu;
    logic [DATA_WIDTH-1:0]        wdata;
    logic                         memread;
    logic                         memwrite;
    logic [RESULT_SRC_LENGTH-1:0] ropcode;
    logic [WMASK_LENGTH-1:0]      wmask;
    logic [RESULT_SRC_LENGTH-1:0] resultsrc;
    logic [DATA_WIDTH-1:0]        csrread;
    logic [REG_ADDR_WIDTH-1:0]    rd;
    logic                         regwrite;

    modport master (
        output valid, pc, alu, wdata, memread, memwrite, ropcode,
               wmask, resultsrc, csrread, rd, regwrite,
        input  ready
    );

    modport slave (
        input  valid, pc, alu, wdata, memread, memwrite, ropcode,
               wmask, resultsrc, csrread, rd, regwrite,
        output ready
    );

endinterface

// File: rtl/pipe_skid_slot.sv
// One pipeline storage slot: a valid bit plus a payload register, with load
// and clear. Clear wins over load and leaves the stale payload in place.
module pipe_skid_slot
    import ysyx_pipe_pkg::*;
#(
    parameter type T = exwb_bundle_t
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic clear,
    input  T     d,
    output logic valid,
    output T     q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the payload is reset too, so a freshly reset boundary presents an all-zero bundle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/exu_wbu_pipe_reg.sv
// EXU -> WBU registered pipeline boundary: main + skid slots give full
// throughput with a registered in_ready, plus a saturating stall counter.
module exu_wbu_pipe_reg
    import ysyx_pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    exu_wbu_pipe_reg_if.slave      exu,
    exu_wbu_pipe_reg_if.master     wbu,
    output logic [31:0]            stall_cnt
);

    exwb_bundle_t in_bundle, main_d, main_q, skid_q;
    logic         main_valid, skid_valid;
    logic         main_load, main_clear, skid_load, skid_clear;
    logic         acc, dep;
    pipe_state_t  state;
    logic [31:0]  stall_cnt_q;

    assign in_bundle = '{pc: exu.pc, alu: exu.alu, wdata: exu.wdata,
                         memread: exu.memread, memwrite: exu.memwrite,
                         ropcode: exu.ropcode, wmask: exu.wmask,
                         resultsrc: exu.resultsrc, csrread: exu.csrread,
                         rd: exu.rd, regwrite: exu.regwrite};

    assign exu.ready = !skid_valid;
    assign acc       = exu.valid & exu.ready;
    assign dep       = main_valid & wbu.ready;
    assign state     = pipe_state(main_valid, skid_valid);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_bundle;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                PIPE_EMPTY: main_load = acc;
                PIPE_ONE: begin
                    if (acc && dep)  main_load  = 1'b1;
                    else if (acc)    skid_load  = 1'b1;
                    else if (dep)    main_clear = 1'b1;
                end
                PIPE_FULL: begin
                    // in_ready is low here, so only a departure can change anything.
                    if (dep) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        skid_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_skid_slot #(.T(exwb_bundle_t)) u_main (
        .clk   (clk),
        .rstn  (rstn),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_skid_slot #(.T(exwb_bundle_t)) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_bundle),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign wbu.valid     = main_valid;
    assign wbu.pc        = main_q.pc;
    assign wbu.alu       = main_q.alu;
    assign wbu.wdata     = main_q.wdata;
    assign wbu.memread   = main_q.memread;
    assign wbu.memwrite  = main_q.memwrite;
    assign wbu.ropcode   = main_q.ropcode;
    assign wbu.wmask     = main_q.wmask;
    assign wbu.resultsrc = main_q.resultsrc;
    assign wbu.csrread   = main_q.csrread;
    assign wbu.rd        = main_q.rd;
    assign wbu.regwrite  = main_q.regwrite;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if (main_valid && !wbu.ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/exu_wbu_pipe_reg.md
Name: exu_wbu_pipe_reg

Overview:
- Registered valid/ready pipeline boundary between the execute unit and the write-back/data-memory stage.
- Captures the EXU result bundle: pc, ALU result, store data, memory controls, result-source select, CSR read value, rd index and RegWrite.
- Presents that bundle to the WBU with full throughput, using a two-entry skid so that in_ready is a registered signal.
- Replaces the direct combinational EXU-to-WBU wiring. The store-data input becomes the pipelined WriteData.

Parameters:
DATA_WIDTH, 32, width of pc, ALU result, store data and CSR read data
RESULT_SRC_LENGTH, 3, width of ResultSrc and Ropcode fields
WMASK_LENGTH, 8, width of the write-strobe mask
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous kill of all held entries (redirect/trap)
in_valid  in  1  EXU bundle valid (Evalid)
in_ready  out  1  boundary can accept a bundle; registered
in_pc  in  DATA_WIDTH  instruction pc
in_alu  in  DATA_WIDTH  ALUResult / memory address
in_wdata  in  DATA_WIDTH  store data (RD2)
in_memread  in  1  load
in_memwrite  in  1  store
in_ropcode  in  RESULT_SRC_LENGTH  load extension opcode
in_wmask  in  WMASK_LENGTH  store byte mask
in_resultsrc  in  RESULT_SRC_LENGTH  result mux select
in_csrread  in  DATA_WIDTH  CSR read value
in_rd  in  REG_ADDR_WIDTH  destination register
in_regwrite  in  1  register write enable
out_valid  out  1  bundle valid to WBU
out_ready  in  1  WBU accepts (Wready)
out_*  out  same widths as in_*  registered bundle (pc, alu, wdata, memread, memwrite, ropcode, wmask, resultsrc, csrread, rd, regwrite)
stall_cnt  out  32  saturating count of cycles with out_valid & !out_ready

Behaviour:
- Reset (rstn low, asynchronous):
  - out_valid=0 and both entries invalid.
  - All out_* payload registers 0; stall_cnt=0.
  - in_ready=1 on the first edge after rstn deasserts.
- Storage: main slot drives out_*; skid slot holds one extra bundle. The state follows from the slot valids:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Handshakes: acc = in_valid & in_ready; dep = out_valid & out_ready. in_ready = !skid_valid.
- Transitions at each edge:
  - EMPTY: acc -> main<=in, go to ONE.
  - ONE: acc & dep -> main<=in, stay ONE. acc & !dep -> skid<=in, go to FULL. !acc & dep -> go to EMPTY.
  - FULL: dep -> main<=skid, go to ONE. acc is impossible because in_ready=0.
- Latency: one cycle from acceptance to out_valid. Sustained throughput is 1 bundle/cycle while out_ready=1.
- Ordering is strictly FIFO; a bundle is never duplicated or dropped. This is required because stores (memwrite=1) must reach the WBU exactly once.
- While out_valid & !out_ready, every out_* signal stays bit-stable.
- out_valid never drops without dep or flush.
- flush:
  - At the edge, both slots are invalidated and any same-cycle acceptance is discarded.
  - Next cycle: out_valid=0, in_ready=1.
  - Payload registers may retain stale values but must not be observable as valid.
  - flush takes priority over acc and dep; a same-cycle dep still counts as consumed by the WBU.
- stall_cnt increments each cycle with out_valid & !out_ready and saturates at 0xFFFFFFFF (no wrap). It is cleared only by reset.
- Payload bits are not masked: memwrite=1 with wmask=0 passes through unchanged.

Decomposition:
- Shared package ysyx_pipe_pkg holds:
  - DATA_WIDTH, RESULT_SRC_LENGTH, WMASK_LENGTH, REG_ADDR_WIDTH constants.
  - A packed exwb_bundle_t struct covering all payload fields, so main and skid are single registers.
- One natural sub-module: pipe_skid_slot, a valid bit plus bundle register with load/clear. It is instantiated twice (main, skid) and later reused for the IFU/IDU boundaries.

Test Plan:
- Reset mid-stream: FULL state with rstn pulsed low for half a cycle -> out_valid=0 immediately, stall_cnt=0, in_ready=1 after release.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_pc=0x80000000+4k -> out_pc sequence 0x80000000..0x8000001C, one per cycle, out_valid from cycle 1 to 8.
- Backpressure:
  - Stimulus: out_ready=0 while sending A(pc 0x100) then B(pc 0x104).
  - Required: in_ready=0 after B; out_pc holds 0x100 stable; stall_cnt counts.
  - Then out_ready=1 -> A then B delivered, each once.
- Store exactly once: a bundle with memwrite=1, wmask=0x0F, wdata=0xDEADBEEF, held under out_ready=0 for 5 cycles -> exactly one dep observed with unchanged payload.
- Flush in FULL: flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle bundle never appears.
- Saturation: force stall_cnt near max (0xFFFFFFFE) and stall 3 cycles -> stall_cnt reads 0xFFFFFFFF and holds.
